// File: rtl/sprite_table.sv
// Double-buffered 16-slot sprite attribute store: host writes land in a shadow bank,
// which is copied wholesale into the active bank on a qualifying frame_sync.
module sprite_table (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_sync,
    input  logic        wr_en,
    input  logic [3:0]  wr_slot,
    input  logic [9:0]  wr_posx,
    input  logic [9:0]  wr_posy,
    input  logic [3:0]  wr_id,
    input  logic        clear_req,
    output logic        busy,
    output logic        pending,
    output logic        committed,
    output logic        wr_drop,
    output logic [9:0]  PosX1,  PosX2,  PosX3,  PosX4,  PosX5,  PosX6,  PosX7,  PosX8,
    output logic [9:0]  PosX9,  PosX10, PosX11, PosX12, PosX13, PosX14, PosX15, PosX16,
    output logic [9:0]  PosY1,  PosY2,  PosY3,  PosY4,  PosY5,  PosY6,  PosY7,  PosY8,
    output logic [9:0]  PosY9,  PosY10, PosY11, PosY12, PosY13, PosY14, PosY15, PosY16,
    output logic [3:0]  SpriteID1,  SpriteID2,  SpriteID3,  SpriteID4,
    output logic [3:0]  SpriteID5,  SpriteID6,  SpriteID7,  SpriteID8,
    output logic [3:0]  SpriteID9,  SpriteID10, SpriteID11, SpriteID12,
    output logic [3:0]  SpriteID13, SpriteID14, SpriteID15, SpriteID16
);

    typedef struct packed {
        logic [9:0] posx;
        logic [9:0] posy;
        logic [3:0] id;
    } slot_t;

    localparam slot_t SLOT_OFF = '{posx: 10'd0, posy: 10'd0, id: 4'hF};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_next;
    logic [3:0] clr_idx;
    slot_t      shadow_bank [16];
    slot_t      active_bank [16];

    logic clear_start, wr_accept, commit, drop, pending_next;

    always_comb begin
        state_next   = state;
        clear_start  = 1'b0;
        wr_accept    = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: begin
                clear_start = clear_req;
                wr_accept   = wr_en && !clear_req;
                commit      = frame_sync && pending;
                drop        = wr_en && clear_req;
                if (clear_req) state_next = CLEAR;
            end
            CLEAR: begin
                drop = wr_en;
                if (clr_idx == 4'd15) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A write in the commit cycle lands after the copy, so it must keep pending set.
        pending_next = (pending && !commit) || wr_accept || clear_start;
    end

    // NOTE: all state here uses non-blocking assignments so the bank copy sees pre-edge
    // shadow contents even when a write to the same slot happens on that edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            clr_idx   <= 4'd0;
            pending   <= 1'b0;
            committed <= 1'b0;
            wr_drop   <= 1'b0;
            // NOTE: both banks are explicitly reset; they are small register files,
            // and the mapper must see every slot disabled right after reset.
            for (int i = 0; i < 16; i++) begin
                shadow_bank[i] <= SLOT_OFF;
                active_bank[i] <= SLOT_OFF;
            end
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            committed <= commit;
            wr_drop   <= drop;

            if (clear_start)
                clr_idx <= 4'd0;
            else if (state == CLEAR)
                clr_idx <= clr_idx + 4'd1;

            if (commit) begin
                for (int i = 0; i < 16; i++)
                    active_bank[i] <= shadow_bank[i];
            end

            if (state == CLEAR)
                shadow_bank[clr_idx] <= SLOT_OFF;
            else if (wr_accept)
                shadow_bank[wr_slot] <= '{posx: wr_posx, posy: wr_posy, id: wr_id};
        end
    end

    assign busy = (state == CLEAR);

    assign PosX1  = active_bank[0].posx;   assign PosY1  = active_bank[0].posy;
    assign PosX2  = active_bank[1].posx;   assign PosY2  = active_bank[1].posy;
    assign PosX3  = active_bank[2].posx;   assign PosY3  = active_bank[2].posy;
    assign PosX4  = active_bank[3].posx;   assign PosY4  = active_bank[3].posy;
    assign PosX5  = active_bank[4].posx;   assign PosY5  = active_bank[4].posy;
    assign PosX6  = active_bank[5].posx;   assign PosY6  = active_bank[5].posy;
    assign PosX7  = active_bank[6].posx;   assign PosY7  = active_bank[6].posy;
    assign PosX8  = active_bank[7].posx;   assign PosY8  = active_bank[7].posy;
    assign PosX9  = active_bank[8].posx;   assign PosY9  = active_bank[8].posy;
    assign PosX10 = active_bank[9].posx;   assign PosY10 = active_bank[9].posy;
    assign PosX11 = active_bank[10].posx;  assign PosY11 = active_bank[10].posy;
    assign PosX12 = active_bank[11].posx;  assign PosY12 = active_bank[11].posy;
    assign PosX13 = active_bank[12].posx;  assign PosY13 = active_bank[12].posy;
    assign PosX14 = active_bank[13].posx;  assign PosY14 = active_bank[13].posy;
    assign PosX15 = active_bank[14].posx;  assign PosY15 = active_bank[14].posy;
    assign PosX16 = active_bank[15].posx;  assign PosY16 = active_bank[15].posy;

    assign SpriteID1  = active_bank[0].id;   assign SpriteID2  = active_bank[1].id;
    assign SpriteID3  = active_bank[2].id;   assign SpriteID4  = active_bank[3].id;
    assign SpriteID5  = active_bank[4].id;   assign SpriteID6  = active_bank[5].id;
    assign SpriteID7  = active_bank[6].id;   assign SpriteID8  = active_bank[7].id;
    assign SpriteID9  = active_bank[8].id;   assign SpriteID10 = active_bank[9].id;
    assign SpriteID11 = active_bank[10].id;  assign SpriteID12 = active_bank[11].id;
    assign SpriteID13 = active_bank[12].id;  assign SpriteID14 = active_bank[13].id;
    assign SpriteID15 = active_bank[14].id;  assign SpriteID16 = active_bank[15].id;

endmodule

// File: tb/tb_sprite_table.sv
// Directed self-checking bench for sprite_table: reset, commit, same-cycle write/commit,
// clear sequence with drops, clear/write collision and reset during clear.
module tb_sprite_table;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_sync = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_slot = '0;
    logic [9:0] wr_posx = '0;
    logic [9:0] wr_posy = '0;
    logic [3:0] wr_id = '0;
    logic       clear_req = 1'b0;
    logic       busy, pending, committed, wr_drop;
    logic [9:0] posx [16];
    logic [9:0] posy [16];
    logic [3:0] sid  [16];

    int total  = 0;
    int passed = 0;

    always #5 Clk = ~Clk;

    sprite_table dut (
        .Clk(Clk), .Reset(Reset), .frame_sync(frame_sync), .wr_en(wr_en),
        .wr_slot(wr_slot), .wr_posx(wr_posx), .wr_posy(wr_posy), .wr_id(wr_id),
        .clear_req(clear_req), .busy(busy), .pending(pending),
        .committed(committed), .wr_drop(wr_drop),
        .PosX1(posx[0]),   .PosX2(posx[1]),   .PosX3(posx[2]),   .PosX4(posx[3]),
        .PosX5(posx[4]),   .PosX6(posx[5]),   .PosX7(posx[6]),   .PosX8(posx[7]),
        .PosX9(posx[8]),   .PosX10(posx[9]),  .PosX11(posx[10]), .PosX12(posx[11]),
        .PosX13(posx[12]), .PosX14(posx[13]), .PosX15(posx[14]), .PosX16(posx[15]),
        .PosY1(posy[0]),   .PosY2(posy[1]),   .PosY3(posy[2]),   .PosY4(posy[3]),
        .PosY5(posy[4]),   .PosY6(posy[5]),   .PosY7(posy[6]),   .PosY8(posy[7]),
        .PosY9(posy[8]),   .PosY10(posy[9]),  .PosY11(posy[10]), .PosY12(posy[11]),
        .PosY13(posy[12]), .PosY14(posy[13]), .PosY15(posy[14]), .PosY16(posy[15]),
        .SpriteID1(sid[0]),   .SpriteID2(sid[1]),   .SpriteID3(sid[2]),   .SpriteID4(sid[3]),
        .SpriteID5(sid[4]),   .SpriteID6(sid[5]),   .SpriteID7(sid[6]),   .SpriteID8(sid[7]),
        .SpriteID9(sid[8]),   .SpriteID10(sid[9]),  .SpriteID11(sid[10]), .SpriteID12(sid[11]),
        .SpriteID13(sid[12]), .SpriteID14(sid[13]), .SpriteID15(sid[14]), .SpriteID16(sid[15])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_write(input int slot, input int x, input int y, input int id);
        wr_en   = 1'b1;
        wr_slot = 4'(slot);
        wr_posx = 10'(x);
        wr_posy = 10'(y);
        wr_id   = 4'(id);
    endtask

    task automatic do_write(input int slot, input int x, input int y, input int id);
        set_write(slot, x, y, id);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic check_all_off(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_id%0d", tag, i + 1), sid[i], 4'hF);
            check($sformatf("%s_px%0d", tag, i + 1), posx[i], 10'd0);
            check($sformatf("%s_py%0d", tag, i + 1), posy[i], 10'd0);
        end
    endtask

    initial begin
        // Reset held for two cycles.
        tick();
        tick();
        Reset = 1'b0;
        check_all_off("rst");
        check("rst_busy", busy, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_committed", committed, 1'b0);
        check("rst_wr_drop", wr_drop, 1'b0);

        // Basic commit: shadow write invisible until frame_sync.
        do_write(2, 100, 50, 3);
        check("basic_pending_set", pending, 1'b1);
        check("basic_id_before", sid[2], 4'hF);
        check("basic_px_before", posx[2], 10'd0);
        tick();
        check("basic_id_idle", sid[2], 4'hF);
        do_sync();
        check("basic_px", posx[2], 10'd100);
        check("basic_py", posy[2], 10'd50);
        check("basic_id", sid[2], 4'd3);
        check("basic_committed", committed, 1'b1);
        check("basic_pending_clr", pending, 1'b0);
        tick();
        check("basic_committed_pulse", committed, 1'b0);

        // Same-cycle write and commit: active takes pre-edge shadow, pending survives.
        do_write(0, 0, 0, 5);
        set_write(0, 0, 0, 7);
        frame_sync = 1'b1;
        tick();
        wr_en = 1'b0;
        frame_sync = 1'b0;
        check("same_id_old", sid[0], 4'd5);
        check("same_committed", committed, 1'b1);
        check("same_pending", pending, 1'b1);
        do_sync();
        check("same_id_new", sid[0], 4'd7);
        check("same_pending_clr", pending, 1'b0);

        // Write with pending=0 and frame_sync: no commit, pending set.
        set_write(4, 20, 30, 9);
        frame_sync = 1'b1;
        tick();
        wr_en = 1'b0;
        frame_sync = 1'b0;
        check("nopend_committed", committed, 1'b0);
        check("nopend_pending", pending, 1'b1);
        check("nopend_id", sid[4], 4'hF);
        do_sync();
        check("nopend_id_late", sid[4], 4'd9);
        // frame_sync with nothing pending gives no pulse.
        do_sync();
        check("idle_sync_committed", committed, 1'b0);

        // Fill every slot, commit, then run a clear.
        for (int i = 0; i < 16; i++) do_write(i, i * 10 + 1, i * 20 + 2, i % 15);
        do_sync();
        check("fill_id8", sid[7], 4'd7);
        check("fill_px16", posx[15], 10'd151);
        check("fill_py16", posy[15], 10'd302);
        check("fill_id16", sid[15], 4'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("clr_busy_c%0d", c), busy, 1'b1);
            if (c == 4) set_write(3, 5, 5, 1);
            frame_sync = (c == 8);
            tick();
            wr_en = 1'b0;
            frame_sync = 1'b0;
            check($sformatf("clr_drop_c%0d", c), wr_drop, (c == 4) ? 1'b1 : 1'b0);
            check($sformatf("clr_nocommit_c%0d", c), committed, 1'b0);
        end
        check("clr_busy_end", busy, 1'b0);
        check("clr_pending", pending, 1'b1);
        check("clr_active_kept", sid[7], 4'd7);
        do_sync();
        check("clr_committed", committed, 1'b1);
        check_all_off("clr");

        // Clear/write collision: clear wins, write dropped.
        clear_req = 1'b1;
        set_write(9, 40, 40, 2);
        tick();
        clear_req = 1'b0;
        wr_en = 1'b0;
        check("coll_drop", wr_drop, 1'b1);
        check("coll_busy", busy, 1'b1);
        for (int c = 0; c < 20 && busy; c++) tick();
        check("coll_busy_done", busy, 1'b0);
        // First non-busy cycle accepts writes.
        do_write(0, 11, 12, 6);
        check("coll_post_nodrop", wr_drop, 1'b0);
        do_sync();
        check("coll_id10", sid[9], 4'hF);
        check("coll_px10", posx[9], 10'd0);
        check("coll_id1", sid[0], 4'd6);

        // Reset at busy cycle 6 aborts the clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        check("rclr_busy6", busy, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rclr_busy", busy, 1'b0);
        check("rclr_pending", pending, 1'b0);
        check("rclr_committed", committed, 1'b0);
        check("rclr_wr_drop", wr_drop, 1'b0);
        check_all_off("rclr");
        do_write(1, 7, 8, 9);
        check("rclr_wr_nodrop", wr_drop, 1'b0);
        check("rclr_wr_pending", pending, 1'b1);
        do_sync();
        check("rclr_px2", posx[1], 10'd7);
        check("rclr_py2", posy[1], 10'd8);
        check("rclr_id2", sid[1], 4'd9);
        check("rclr_id1_off", sid[0], 4'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sprite_table.md
# sprite_table

Double-buffered 16-slot sprite attribute store feeding the sprite mapper stage. Host logic writes per-slot position and sprite ID into a shadow bank at any time. The shadow bank is copied atomically into the active bank on a frame-boundary pulse, so the mapper never sees a half-updated sprite list mid-frame. A bulk-clear sequencer disables all 16 slots in 16 cycles.

## Interface
Parameters:
- none. Slot count fixed at 16, position width 10, ID width 4, disabled ID = 4'hF.

Ports:
- Clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- Reset  in  1  synchronous, active-high reset.
- frame_sync  in  1  one-cycle pulse at start of vertical blank.
- wr_en  in  1  write strobe for one shadow slot.
- wr_slot  in  4  target slot 0..15. Slot k drives output group k+1.
- wr_posx  in  10  top-left X of sprite.
- wr_posy  in  10  top-left Y of sprite.
- wr_id  in  4  sprite ID; 4'hF = slot disabled.
- clear_req  in  1  request bulk clear of the shadow bank.
- busy  out  1  high while the clear sequence runs.
- pending  out  1  shadow bank differs from active bank, i.e. written since last commit.
- committed  out  1  one-cycle pulse; active bank updated this cycle.
- wr_drop  out  1  one-cycle pulse; previous-cycle write was discarded.
- PosXn, PosYn  out  10 each  active-bank position of slot n, n = 1..16.
- SpriteIDn  out  4 each  active-bank ID of slot n, n = 1..16.

## Operation
- Storage: shadow bank and active bank, each 16 × {posx[9:0], posy[9:0], id[3:0]}. All outputs are driven directly from active-bank registers.
- FSM states:
  - IDLE:
    - clear_req=1 → CLEAR with clr_idx=0. pending is set.
    - Otherwise, wr_en=1 writes shadow[wr_slot] and sets pending.
  - CLEAR:
    - Each cycle writes shadow[clr_idx] = {0, 0, 4'hF}, then increments clr_idx.
    - After writing slot 15, returns to IDLE.
    - clear_req is ignored in this state.
- busy = (state == CLEAR).
- Write drops:
  - wr_en=1 while busy=1: write discarded; wr_drop=1 next cycle.
  - wr_en=1 and clear_req=1 in the same IDLE cycle: clear wins; write discarded; wr_drop=1 next cycle.
- Commit:
  - Condition: frame_sync=1, pending=1 and state=IDLE.
  - Action: all 48 active fields load from shadow on that edge; pending clears; committed=1 for the following cycle.
- Skipped commit:
  - frame_sync=1 while busy=1: no copy. pending stays 1, so the commit happens at the next qualifying frame_sync.
  - frame_sync=1 with pending=0: no copy and no committed pulse.
- Write and commit in the same cycle (wr_en=1, frame_sync=1, pending=1, IDLE):
  - The active bank takes the shadow contents from before the edge.
  - The write lands in shadow, and pending ends at 1 (the write survives the clear of pending).
- Write with pending=0 and frame_sync=1: the write lands in shadow; pending ends at 1; no commit.
- Reset:
  - Both banks go to all IDs = 4'hF and all positions = 0.
  - State = IDLE, clr_idx = 0.
  - pending, committed, wr_drop, busy = 0.
  - Reset during CLEAR aborts the sequence with the same values.

## Timing
- Write latency:
  - Shadow updates at the edge sampling wr_en.
  - The value reaches the outputs at the edge of the next qualifying frame_sync, so it is visible the cycle after that edge.
- Clear:
  - The edge sampling clear_req enters CLEAR.
  - busy is high for exactly 16 cycles; slots are cleared in ascending order, 0..15.
  - The first cycle with busy=0 accepts writes.
- committed and wr_drop are registered single-cycle pulses. Each is high in the cycle after the triggering edge.
- Active bank changes only on commit edges or Reset. All 16 slots change on the same edge.
- No combinational path from any input to any output.

## Test plan
- Reset: drive Reset for 2 cycles → all SpriteIDn = 4'hF, all PosXn/PosYn = 0, busy/pending/committed/wr_drop = 0.
- Basic commit: write slot 2 = {posx 100, posy 50, id 3}; outputs stay unchanged → pulse frame_sync → next cycle PosX3 = 100, PosY3 = 50, SpriteID3 = 3, committed = 1, pending = 0.
- Same-cycle write and commit:
  - Write slot 0 id 5 and commit it.
  - Then write slot 0 id 7 in the same cycle as frame_sync.
  - Required: SpriteID1 = 5 and pending = 1; a second frame_sync gives SpriteID1 = 7.
- Clear sequence:
  - After filling all slots, assert clear_req → busy high exactly 16 cycles.
  - A write at busy cycle 4 gives wr_drop = 1; a frame_sync at busy cycle 8 gives no commit.
  - The next frame_sync after busy falls gives all SpriteIDn = 4'hF.
- Clear/write collision: clear_req and wr_en (slot 9, id 2) in the same cycle → wr_drop = 1; after clear and commit, SpriteID10 = 4'hF.
- Reset mid-clear: Reset at busy cycle 6 → busy = 0 next cycle, all reset values, and a following write to slot 1 is accepted.
